raw_tx_scheduler: RTL

- Shares the raw Ethernet TX byte channel (tx_req/tx_len/tx_ack/tx_gate/tx_byte) between NUM_CLIENT word-oriented requesters.
- Round-robin arbitration per packet, then serialization of the granted client's NUM_BYTE-wide words into bytes, MSB first.
- Sits between the local packet sources and the MAC-side TX port.
- Replaces a single-source TX gateway when several sources need the port.

---
 rtl/raw_tx_scheduler.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/raw_tx_scheduler.sv
// raw_tx_scheduler: round-robin share of the raw TX byte channel between
// NUM_CLIENT word sources. A granted client's words are serialized MSB first.
//
// state | meaning
// IDLE  | no packet; arbitrate among cl_req
// REQ   | tx_req high, waiting for a fresh tx_ack rising edge
// SEND  | streaming bytes, one per tx_gate
// ZLEN  | zero-length packet granted; cl_done pulses next, no tx_req
// GAP   | packet finished; wait for tx_ack low before rearbitrating
module raw_tx_scheduler #(
  parameter int NUM_CLIENT  = 4,
  parameter int NUM_BYTE    = 8,
  parameter int TXLEN_WIDTH = 11
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_CLIENT-1:0]             cl_req,
  input  logic [NUM_CLIENT*TXLEN_WIDTH-1:0] cl_len,
  input  logic [NUM_CLIENT*NUM_BYTE*8-1:0]  cl_data,
  output logic [NUM_CLIENT-1:0]             cl_grant,
  output logic [NUM_CLIENT-1:0]             cl_data_gate,
  output logic [NUM_CLIENT-1:0]             cl_done,
  output logic                              busy,
  output logic                              tx_req,
  output logic [TXLEN_WIDTH-1:0]            tx_len,
  input  logic                              tx_ack,
  input  logic                              tx_gate,
  output logic [7:0]                        tx_byte
);

  localparam int DWIDTH = NUM_BYTE * 8;
  localparam int IDXW   = (NUM_CLIENT > 1) ? $clog2(NUM_CLIENT) : 1;
  localparam int OCTW   = (NUM_BYTE > 1) ? $clog2(NUM_BYTE) : 1;
  localparam logic [IDXW-1:0] LAST_RST = IDXW'(NUM_CLIENT - 1);
  localparam logic [OCTW-1:0] OCT_MAX  = OCTW'(NUM_BYTE - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_SEND = 3'd2,
    ST_ZLEN = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic [IDXW-1:0]         last_q, last_d;
  logic [TXLEN_WIDTH-1:0]  len_q, len_d;
  logic [TXLEN_WIDTH-1:0]  left_q, left_d;
  logic [OCTW-1:0]         octet_q, octet_d;
  logic [DWIDTH-1:0]       shreg_q, shreg_d;
  logic [NUM_CLIENT-1:0]   grant_q, grant_d;
  logic [NUM_CLIENT-1:0]   done_q, done_d;
  logic                    tx_req_q, tx_req_d;
  logic [TXLEN_WIDTH-1:0]  tx_len_q, tx_len_d;
  logic                    ack_q;
  logic [NUM_CLIENT-1:0]   data_gate;

  logic [TXLEN_WIDTH-1:0]  len_arr  [NUM_CLIENT];
  logic [DWIDTH-1:0]       data_arr [NUM_CLIENT];
  logic [IDXW-1:0]         win_idx;
  logic [IDXW-1:0]         rr_cand;
  logic                    win_ok;

  for (genvar g = 0; g < NUM_CLIENT; g++) begin : g_unpack
    assign len_arr[g]  = cl_len[g*TXLEN_WIDTH +: TXLEN_WIDTH];
    assign data_arr[g] = cl_data[g*DWIDTH +: DWIDTH];
  end

  // Round robin: scan downward so the nearest requester after last_q wins.
  always_comb begin
    win_idx = last_q;
    win_ok  = 1'b0;
    rr_cand = last_q;
    for (int k = NUM_CLIENT; k >= 1; k--) begin
      rr_cand = IDXW'((int'(last_q) + k) % NUM_CLIENT);
      if (cl_req[rr_cand]) begin
        win_idx = rr_cand;
        win_ok  = 1'b1;
      end
    end
  end

  // Next-state and datapath updates; cl_data_gate is asserted in the same
  // cycle the word is captured so the client can advance on that edge.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    len_d     = len_q;
    left_d    = left_q;
    octet_d   = octet_q;
    shreg_d   = shreg_q;
    grant_d   = grant_q;
    done_d    = '0;
    tx_req_d  = tx_req_q;
    tx_len_d  = tx_len_q;
    data_gate = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_ok) begin
          idx_d            = win_idx;
          last_d           = win_idx;
          len_d            = len_arr[win_idx];
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          if (len_arr[win_idx] != '0) begin
            tx_req_d = 1'b1;
            tx_len_d = len_arr[win_idx];
            state_d  = ST_REQ;
          end else begin
            state_d  = ST_ZLEN;
          end
        end
      end
      ST_REQ: begin
        if (tx_ack && !ack_q) begin
          shreg_d          = data_arr[idx_q];
          data_gate[idx_q] = 1'b1;
          left_d           = len_q;
          octet_d          = '0;
          state_d          = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_gate) begin
          left_d = left_q - TXLEN_WIDTH'(1);
          if (left_q == TXLEN_WIDTH'(1)) begin
            tx_req_d      = 1'b0;
            tx_len_d      = '0;
            done_d[idx_q] = 1'b1;
            grant_d       = '0;
            shreg_d       = '0;
            state_d       = ST_GAP;
          end else if (octet_q == OCT_MAX) begin
            shreg_d          = data_arr[idx_q];
            data_gate[idx_q] = 1'b1;
            octet_d          = '0;
          end else begin
            shreg_d = shreg_q << 8;
            octet_d = octet_q + OCTW'(1);
          end
        end
      end
      ST_ZLEN: begin
        done_d[idx_q] = 1'b1;
        grant_d       = '0;
        state_d       = ST_GAP;
      end
      ST_GAP: begin
        if (!tx_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; tx_ack is delayed every cycle for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      last_q   <= LAST_RST;
      len_q    <= '0;
      left_q   <= '0;
      octet_q  <= '0;
      shreg_q  <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      tx_req_q <= 1'b0;
      tx_len_q <= '0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      len_q    <= len_d;
      left_q   <= left_d;
      octet_q  <= octet_d;
      shreg_q  <= shreg_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      tx_req_q <= tx_req_d;
      tx_len_q <= tx_len_d;
      ack_q    <= tx_ack;
    end
  end

  assign cl_grant     = grant_q;
  assign cl_data_gate = data_gate;
  assign cl_done      = done_q;
  assign busy         = (state_q != ST_IDLE);
  assign tx_req       = tx_req_q;
  assign tx_len       = tx_len_q;
  assign tx_byte      = shreg_q[DWIDTH-1 -: 8];

endmodule
